// File: rtl/fprint_fifo_pkg.sv
// Shared definitions for the fingerprint FIFO and the comparator datapath.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fprint_fifo_pkg;

    // Read-mode encodings for the FWFT parameter.
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Widest word the shared parity function accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 64;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2w(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Even parity bit: XOR of all data bits, so data plus parity has an even number of ones.
    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fprint_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port (sync or async read).
// Latency: write 1 cycle; read 1 cycle (ASYNC_READ=0) or combinational (ASYNC_READ=1).
// Backpressure: none; the caller gates we/re.
// Ports: clk, rst (resets only the sync read register), we/waddr/wdata write port,
//        re/raddr/rdata read port, clr synchronously zeroes the sync read register.
module fprint_fifo_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ASYNC_READ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (ASYNC_READ != 0) begin : g_async
            logic unused_sync_ctrl;
            assign unused_sync_ctrl = ^{rst, re, clr};
            assign rdata = mem[raddr];
        end else begin : g_sync
            logic [WIDTH-1:0] rdata_q;
            // The output register is reset/cleared so the FIFO's data_out starts at 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (clr) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fprint_fifo.sv
// Single-clock fingerprint/CRC FIFO, full 2**ADDR_WIDTH depth, count, thresholds, flush, sticky errors.
// Latency: standard mode data_out 1 cycle after rd_en; FWFT mode head word visible the cycle after write.
// Backpressure: writes while full are dropped (overflow), reads while empty ignored (underflow).
// Ports: clk, rst (async, active-high), flush, wr_en/data_in, rd_en/data_out, full/empty,
//        almost_full/almost_empty, count, overflow/underflow/parity_err (sticky), clr_err.
// Optional: define FIFO_PARITY_EN to store and check an even-parity bit per word.
module fprint_fifo
    import fprint_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef FIFO_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] CNT_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_L     = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L     = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ov_set;
    logic                  un_set;
    logic [RAM_W-1:0]      ram_wdata;
    logic [RAM_W-1:0]      ram_rdata;

    // Flags decode the registered count only, so they cannot glitch on input changes.
    assign count        = count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);

    // Flush swallows both requests, including their error side effects.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;
    assign ov_set = wr_en & full  & ~flush;
    assign un_set = rd_en & empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ov_set)       overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (un_set)       underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

`ifdef FIFO_PARITY_EN
    logic [PAR_MAX_W-1:0] wr_ext;
    logic [PAR_MAX_W-1:0] rd_ext;
    logic                 chk_vld;
    logic                 par_bad;

    always_comb begin
        wr_ext = '0;
        wr_ext[DATA_WIDTH-1:0] = data_in;
        rd_ext = '0;
        rd_ext[DATA_WIDTH-1:0] = ram_rdata[DATA_WIDTH-1:0];
    end

    assign ram_wdata = {parity_of(wr_ext), data_in};

    // FWFT checks the head word as it is popped; standard mode checks the word
    // in the read register the cycle after it was loaded.
    if (FWFT == MODE_FWFT) begin : g_chk_fwft
        assign chk_vld = rd_acc;
    end else begin : g_chk_std
        logic rd_acc_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_acc_q <= 1'b0;
            else     rd_acc_q <= rd_acc;
        end
        assign chk_vld = rd_acc_q;
    end

    assign par_bad = chk_vld & (parity_of(rd_ext) != ram_rdata[DATA_WIDTH]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          parity_err <= 1'b0;
        else if (par_bad) parity_err <= 1'b1;
        else if (clr_err) parity_err <= 1'b0;
    end
`else
    assign ram_wdata  = data_in;
    assign parity_err = 1'b0;
`endif

    fprint_fifo_ram #(
        .WIDTH      (RAM_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ASYNC_READ ((FWFT == MODE_FWFT) ? 1 : 0)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .clr   (flush),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_out_fwft
            // Stale RAM contents are masked while empty.
            assign data_out = empty ? '0 : ram_rdata[DATA_WIDTH-1:0];
        end else begin : g_out_std
            assign data_out = ram_rdata[DATA_WIDTH-1:0];
        end
    endgenerate

endmodule
